// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
// chunks of CW bits; each stage adds one chunk and hands its carry to the next
// stage through a register, so no path crosses more than CW bits of carry.
// The whole pipeline advances as one unit under a single valid/ready stall.

module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   logic advance;
   logic ovf_q;

   // Pipeline moves only when the output slot is empty or being drained.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic [WIDTH-1:0] s_next;
      logic             c_in;
      logic             v_in;
      logic [CW:0]      chunk;

      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;

      if (k == 0) begin : g_first
         // Subtract is a + ~b + 1: invert b here and force the carry-in.
         assign a_in = a;
         assign b_in = sub ? ~b : b;
         assign c_in = sub | cin;
         assign v_in = in_valid;
         assign s_in = '0;
      end else begin : g_next
         assign a_in = g_stage[k-1].a_q;
         assign b_in = g_stage[k-1].b_q;
         assign c_in = g_stage[k-1].c_q;
         assign v_in = g_stage[k-1].v_q;
         assign s_in = g_stage[k-1].s_q;
      end

      assign chunk = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]}
                   + {{CW{1'b0}}, c_in};

      // Drop this stage's chunk result into the partial sum word.
      always_comb begin
         s_next              = s_in;
         s_next[k*CW +: CW]  = chunk[CW-1:0];
      end

      // Stage register: holds while stalled, cleared by reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else if (advance) begin
            a_q <= a_in;
            b_q <= b_in;
            s_q <= s_next;
            c_q <= chunk[CW];
            v_q <= v_in;
         end
      end

      if (k == STAGES - 1) begin : g_ovf
         // Signed overflow is resolved in the MSB chunk alongside its sum.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                        (chunk[CW-1] != a_in[WIDTH-1]);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vector table, backpressure stream,
// mid-flight reset and a random sweep over several WIDTH/STAGES settings.

module tb_pipelined_addsub;

   localparam int PERIOD = 10;

   typedef struct {
      logic [63:0] sum;
      logic [1:0]  co;
      longint      t;
      int          stalls;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        sweep_start = 1'b0;

   exp_t        q[$];
   int          stall_cnt = 0;
   logic        hold_prev = 1'b0;
   logic [15:0] hold_sum;
   logic [1:0]  hold_co;

   always #(PERIOD/2) clk = ~clk;

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] model16(logic [15:0] x, logic [15:0] y, logic c, logic s);
      logic [15:0] be;
      logic [16:0] f;
      logic        o;
      be = s ? ~y : y;
      f  = {1'b0, x} + {1'b0, be} + {16'b0, (s ? 1'b1 : c)};
      o  = (x[15] == be[15]) && (f[15] != x[15]);
      return {f[16], o, f[15:0]};
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic ts, input logic [15:0] es, input logic eco, input logic eov);
      exp_t e;
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            e.sum = 64'(es); e.co = {eco, eov}; e.t = longint'($time); e.stalls = stall_cnt;
            q.push_back(e);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 60 && q.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      chk(nm, 64'(q.size()), 64'(0));
   endtask

   // Main scoreboard, output-hold and stall checks, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_sum", 64'(sum), 64'(hold_sum));
            chk("hold_flags", 64'({cout, ovf}), 64'(hold_co));
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            stall_cnt++;
            hold_prev = 1'b1;
            hold_sum  = sum;
            hold_co   = {cout, ovf};
         end else begin
            hold_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'(sum), 64'hDEAD_0000_0000_0000);
            end else begin
               e = q.pop_front();
               chk("res_sum", 64'(sum), e.sum);
               chk("res_flags", 64'({cout, ovf}), 64'(e.co));
               if (e.stalls == stall_cnt)
                  chk("latency", 64'((longint'($time) - e.t) / PERIOD), 64'(4));
            end
         end
      end
   end

   // Random sweep over other parameter sets against a golden model.
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int W = (g == 0) ? 4 : (g == 1) ? 4 : (g == 2) ? 32 : 64;
      localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8  : 4;

      logic         s_iv = 1'b0, s_ir, s_ov, s_or = 1'b1, s_cin = 1'b0, s_sub = 1'b0;
      logic         s_co, s_ovf;
      logic [W-1:0] s_a = '0, s_b = '0, s_sum;
      logic         done = 1'b0;
      exp_t         sq[$];
      int           acc = 0;
      int           stalls = 0;
      logic [W-1:0] m_be;
      logic [64:0]  m_full;
      logic [63:0]  r;

      pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut_sw (
         .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
         .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
         .out_valid(s_ov), .out_ready(s_or),
         .sum(s_sum), .cout(s_co), .ovf(s_ovf)
      );

      always @(negedge clk) begin
         exp_t e;
         if (rst) begin
            sq.delete();
         end else begin
            if (s_ov && s_or) begin
               if (sq.size() == 0) begin
                  chk($sformatf("sw%0d_unexpected", g), 64'(s_sum), 64'hDEAD_0000_0000_0000);
               end else begin
                  e = sq.pop_front();
                  chk($sformatf("sw%0d_sum", g), 64'(s_sum), e.sum);
                  chk($sformatf("sw%0d_flags", g), 64'({s_co, s_ovf}), 64'(e.co));
                  if (e.stalls == stalls)
                     chk($sformatf("sw%0d_latency", g),
                         64'((longint'($time) - e.t) / PERIOD), 64'(S));
               end
            end
            if (s_ov && !s_or) stalls++;
            if (s_iv && s_ir) begin
               m_be   = s_sub ? ~s_b : s_b;
               m_full = 65'(s_a) + 65'(m_be) + 65'(s_sub | s_cin);
               e.sum  = 64'(m_full[W-1:0]);
               e.co   = {m_full[W], (s_a[W-1] == m_be[W-1]) && (m_full[W-1] != s_a[W-1])};
               e.t    = longint'($time);
               e.stalls = stalls;
               sq.push_back(e);
               acc++;
            end
         end
      end

      initial begin
         wait (sweep_start);
         @(posedge clk); #1;
         for (int i = 0; i < 2000 && acc < 40; i++) begin
            r     = {$urandom(), $urandom()};
            s_a   = r[W-1:0];
            r     = {$urandom(), $urandom()};
            s_b   = r[W-1:0];
            if (i % 7 == 3) s_b = ~s_a;
            s_cin = 1'($urandom_range(0, 1));
            s_sub = 1'($urandom_range(0, 1));
            s_iv  = ($urandom_range(0, 3) != 0);
            s_or  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
         end
         s_iv = 1'b0;
         s_or = 1'b1;
         for (int i = 0; i < 100 && sq.size() > 0; i++) begin
            @(posedge clk); #1;
         end
         chk($sformatf("sw%0d_drain", g), 64'(sq.size()), 64'(0));
         chk($sformatf("sw%0d_accepts", g), 64'(acc >= 40), 64'(1));
         done = 1'b1;
      end
   end

   vec_t vecs[8];

   initial begin
      logic [17:0] m;
      logic        all_done;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_flags", 64'({cout, ovf}), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      // Directed vectors, back to back.
      for (int i = 0; i < 8; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
              vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      in_valid = 1'b0;
      drain("vec_drain");

      // Eight-beat stream with a three-cycle output stall in the middle.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               m = model16(16'(i * 16'h1357 + 16'h0100), 16'(i * 16'h0F21), i[1], i[0]);
               send(16'(i * 16'h1357 + 16'h0100), 16'(i * 16'h0F21), i[1], i[0],
                    m[15:0], m[17], m[16]);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("stream_drain");

      // Three beats in flight, then reset; a beat offered during reset is dropped.
      for (int i = 0; i < 3; i++) begin
         m = model16(16'(16'h0A00 + i), 16'h0033, 1'b0, 1'b0);
         send(16'(16'h0A00 + i), 16'h0033, 1'b0, 1'b0, m[15:0], m[17], m[16]);
      end
      rst = 1'b1;
      a = 16'h4444; b = 16'h1111; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_sum", 64'(sum), 64'(0));
      chk("midrst_flags", 64'({cout, ovf}), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_queue", 64'(q.size()), 64'(0));
      send(16'h0101, 16'h0202, 1'b1, 1'b0, 16'h0304, 1'b0, 1'b0);
      in_valid = 1'b0;
      drain("post_rst_drain");
      repeat (8) @(posedge clk);
      #1;

      sweep_start = 1'b1;
      all_done = 1'b0;
      for (int i = 0; i < 5000 && !all_done; i++) begin
         @(posedge clk); #1;
         all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
      end
      chk("sweep_done", 64'(all_done), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
